fc_sched: RTL
=============

# fc_sched

Scheduler that shares one fc_layer instance between two requesters: the RISC-V core's MMIO port (requester 0) and the conv pipeline (requester 1). It arbitrates round-robin and latches the winner's operands. It then pulses the engine start, waits for done, and returns the packed 32-bit score to the owning requester over a valid/ready response channel. It sits between the requesters and fc_layer and is the only block that drives fc_layer's start and operand inputs.

## Interface
- TIMEOUT, 16: maximum cycles in WAIT before an error response; legal range 1..255. Used only when FC_SCHED_TIMEOUT_EN is defined.
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  2  per-requester operation request
- req_ready  output  2  one-hot accept strobe; the request is accepted when valid and ready are both high
- req_in_flat  input  64  requester r inputs at [r*32 +: 32]
- req_weights_flat  input  256  requester r weights at [r*128 +: 128]
- req_bias  input  64  requester r biases at [r*32 +: 32]
- resp_valid  output  2  one-hot response valid to the owning requester
- resp_ready  input  2  per-requester response accept
- resp_data  output  32  score returned to the owner
- resp_err  output  1  qualifies resp_data; 1 means the operation timed out
- busy  output  1  high in every state except IDLE
- fc_start  output  1  single-cycle start pulse to fc_layer
- fc_in_flat  output  32  registered operands to fc_layer
- fc_weights_flat  output  128  registered operands to fc_layer
- fc_bias  output  32  registered operands to fc_layer
- fc_out_score  input  32  fc_layer result
- fc_done  input  1  fc_layer completion pulse

## Operation
- FSM states and transitions:
  - IDLE: if any req_valid is set, grant one requester, register its operands into fc_in_flat, fc_weights_flat and fc_bias, pulse req_ready[grant], then go to ISSUE.
  - ISSUE: drive fc_start=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
  - WAIT: on fc_done, capture fc_out_score into resp_data, set resp_err=0, then go to RESP.
  - RESP: hold resp_valid[owner] and resp_data until resp_ready[owner] is high. Then drop resp_valid, update last_grant to the owner, and go to IDLE.
- Arbitration is round-robin on last_grant.
  - When both requesters are valid, the grant goes to the requester that was not last granted.
  - When one requester is valid, it wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Operand registers hold stable from the accept cycle until the next accept. This is required because fc_layer samples fc_in_flat combinationally during its COMPUTE state.
- resp_ready on the non-owner bit is ignored. req_valid is ignored outside IDLE, and req_ready stays 0 there.
- fc_done in IDLE, ISSUE or RESP is ignored; it is a stray pulse.
- Reset mid-operation returns the block to IDLE and clears all outputs. Reset of fc_layer shares the same reset net.
- Reset values:
  - req_ready=0, resp_valid=0, resp_err=0, busy=0, fc_start=0.
  - resp_data=0, fc_in_flat=0, fc_weights_flat=0, fc_bias=0.
  - last_grant=1, state=IDLE.

## Timing
- Cycle A: req_valid is high in IDLE, so req_ready[g]=1 is registered and visible in cycle A+1 together with the operands. The state is ISSUE in A+1.
- Cycle A+1: fc_start=1. fc_layer samples it at the end of A+1.
- fc_done arrives 4 cycles after the fc_start edge with the current fc_layer, but the scheduler waits on fc_done and does not count cycles.
- resp_valid rises the cycle after fc_done is sampled.
- Minimum accept-to-resp_valid is 6 cycles.
- The earliest next accept is the cycle after the resp_valid && resp_ready handshake. Back-to-back throughput is 1 operation per 7 cycles when resp_ready is tied high.
- A requester must hold req_valid and its operands until req_ready is seen. A request dropped before grant is simply not served.

## Configuration
- FC_SCHED_TIMEOUT_EN defined:
  - An 8-bit counter increments on every WAIT cycle.
  - When the counter reaches TIMEOUT without fc_done, the block goes to RESP with resp_data=0 and resp_err=1.
  - fc_done on the same cycle as expiry wins: the response is normal with resp_err=0.
- FC_SCHED_TIMEOUT_EN undefined:
  - No counter is built, and WAIT waits indefinitely.
  - resp_err is tied to 0.

## Test plan
- Single request: requester 0 sends in_flat=0x01010101, all weights 0x01, bias=0 -> one req_ready[0] pulse, one fc_start pulse, resp_valid[0] with resp_data=0x04040404, resp_err=0, minimum latency of 6 cycles.
- Simultaneous requests: both req_valid are high after reset -> requester 0 is served first, then requester 1. On a second simultaneous pair, requester 0 is served first again, because last_grant is 1 after serving requester 1.
- Response backpressure: hold resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_data stay stable, busy=1, req_ready stays 0 even with req_valid[0] high.
- Timeout (macro defined, TIMEOUT=16): a stubbed engine never asserts fc_done -> resp_err=1, resp_data=0 after 16 WAIT cycles. A later stray fc_done in IDLE is ignored.
- Reset in WAIT: assert reset for one cycle -> all outputs return to 0 and busy=0. The next request completes normally with the correct score.

Source files
------------

// File: rtl/fc_sched.sv
// fc_sched: round-robin scheduler that shares one fc_layer between two requesters.
// Define FC_SCHED_TIMEOUT_EN to build the WAIT-state timeout and error response.
module fc_sched #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [63:0]  req_in_flat,
    input  logic [255:0] req_weights_flat,
    input  logic [63:0]  req_bias,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [31:0]  resp_data,
    output logic         resp_err,
    output logic         busy,
    output logic         fc_start,
    output logic [31:0]  fc_in_flat,
    output logic [127:0] fc_weights_flat,
    output logic [31:0]  fc_bias,
    input  logic [31:0]  fc_out_score,
    input  logic         fc_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nx;
    logic   owner;
    logic   last_grant;
    logic   grant;
    logic   accept;
    logic   resp_fire;
    logic   expired;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("fc_sched: TIMEOUT must be in 1..255");
    end

    // Tie goes to the requester that was not granted last.
    assign grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign accept    = (state == IDLE) && (req_valid != 2'b00);
    assign resp_fire = (state == RESP) && resp_ready[owner];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: defaults first, so every path assigns state_nx and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid != 2'b00)  state_nx = ISSUE;
            ISSUE:                            state_nx = WAIT;
            WAIT:    if (fc_done || expired)  state_nx = RESP;
            RESP:    if (resp_ready[owner])   state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    // Handshake strobes decode from registered state, so they are glitch-free with no input path.
    always_comb begin
        busy       = (state != IDLE);
        fc_start   = (state == ISSUE);
        req_ready  = (state == ISSUE) ? {owner, ~owner} : 2'b00;
        resp_valid = (state == RESP)  ? {owner, ~owner} : 2'b00;
    end

    // Operands stay put until the next accept because fc_layer reads them combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            fc_in_flat      <= '0;
            fc_weights_flat <= '0;
            fc_bias         <= '0;
        end else begin
            if (accept) begin
                owner           <= grant;
                fc_in_flat      <= grant ? req_in_flat[63:32]       : req_in_flat[31:0];
                fc_weights_flat <= grant ? req_weights_flat[255:128] : req_weights_flat[127:0];
                fc_bias         <= grant ? req_bias[63:32]          : req_bias[31:0];
            end
            if (resp_fire) last_grant <= owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data <= '0;
        end else if (state == WAIT) begin
            if (fc_done)      resp_data <= fc_out_score;
            else if (expired) resp_data <= '0;
        end
    end

`ifdef FC_SCHED_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt;

    // Expiry fires on the TIMEOUT-th WAIT cycle; a coincident fc_done takes priority.
    assign expired = (state == WAIT) && (tmo_cnt == TMO_LAST) && !fc_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 8'd1;
            if (state == WAIT) begin
                if (fc_done)      resp_err <= 1'b0;
                else if (expired) resp_err <= 1'b1;
            end
        end
    end
`else
    assign expired  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule
